// File: rtl/triple_acc.sv
// Batch accumulator: sums N_SAMPLES handshaked samples, then holds the result until taken downstream.
// Define TRIPLE_ACC_SATURATE_EN to clamp on overflow; otherwise the sum wraps.
module triple_acc #(
  parameter int N_SAMPLES = 8,
  parameter int SUM_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [3:0]       cnt
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state, state_nx;
  logic [SUM_W-1:0] sum;
  logic             ovf;
  // One bit wider than cnt so that N_SAMPLES=16 can be reached without wrapping.
  logic [4:0]       count;
  logic [SUM_W:0]   add;
  logic             take;
  logic             last;

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign take      = in_valid && in_ready;
  assign add       = {1'b0, sum} + (SUM_W+1)'(in_data);
  assign last      = ((count + 5'd1) == 5'(N_SAMPLES));

  assign out_sum = sum;
  assign out_ovf = ovf;
  assign cnt     = count[3:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, ACC: if (take) state_nx = last ? DONE : ACC;
      DONE:      if (out_ready) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else if (take && state == IDLE) begin
      sum   <= SUM_W'(in_data);
      ovf   <= 1'b0;
      count <= 5'd1;
    end else if (take) begin
      count <= count + 5'd1;
      if (add[SUM_W]) ovf <= 1'b1;
`ifdef TRIPLE_ACC_SATURATE_EN
      // Once clamped, the sum stays pinned at full scale for the rest of the batch.
      if (add[SUM_W] || ovf) sum <= '1;
      else                   sum <= add[SUM_W-1:0];
`else
      sum <= add[SUM_W-1:0];
`endif
    end else if (state == DONE && out_ready) begin
      count <= '0;
    end
  end

endmodule

// File: doc/triple_acc.md
TRIPLE_ACC -- requirements
Module: triple_acc

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 8, meaning the number of input samples summed per batch (legal range 1..16).
REQ-002 SHALL have parameter SUM_W, default 12, meaning the width of the accumulator and of out_sum (legal range 10..16).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream sample present.
REQ-006 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-007 SHALL have port in_data  input  10  unsigned sample, the output of the triple stage (range 0..765).
REQ-008 SHALL have port out_valid  output  1  batch result present.
REQ-009 SHALL have port out_ready  input  1  downstream takes the result this cycle.
REQ-010 SHALL have port out_sum  output  SUM_W  unsigned batch sum.
REQ-011 SHALL have port out_ovf  output  1  an overflow occurred during this batch.
REQ-012 SHALL have port cnt  output  4  samples accepted in the current batch.

Function
REQ-013 SHALL count an input transfer only on a clock edge where in_valid && in_ready are both 1.
REQ-014 SHALL count an output transfer only on a clock edge where out_valid && out_ready are both 1.
REQ-015 SHALL implement a 3-state FSM with states IDLE, ACC and DONE.
REQ-016 In IDLE: in_ready=1 and out_valid=0; an input transfer loads sum=in_data, sets cnt=1 and clears out_ovf; next state is ACC, or DONE if N_SAMPLES=1.
REQ-017 In ACC: in_ready=1 and out_valid=0; an input transfer adds in_data to sum and increments cnt; next state is DONE when cnt reaches N_SAMPLES, otherwise ACC.
REQ-018 In DONE: in_ready=0 and out_valid=1; out_sum, out_ovf and cnt stay stable until an output transfer, which moves the FSM to IDLE with cnt=0.
REQ-019 out_valid SHALL rise on the clock edge that accepts the N_SAMPLES-th sample, so it is visible in the cycle after that handshake (latency 1).
REQ-020 While in IDLE or ACC, a cycle with in_valid=0 SHALL leave sum and cnt unchanged.
REQ-021 In DONE, in_valid SHALL be ignored and no sample SHALL be consumed, whatever its value.
REQ-022 Addition SHALL be unsigned; in_data is zero-extended to SUM_W+1 bits; bit SUM_W of the result is the overflow carry.
REQ-023 out_ovf SHALL be sticky within a batch: it is set on any carry and cleared only when the first sample of the next batch is accepted.
REQ-024 out_sum SHALL equal the internal sum at all times; the internal sum is visible during accumulation, but out_sum is meaningful only while out_valid=1.
REQ-025 No back-to-back overlap: at most one batch is in flight, so the first sample of the next batch is accepted no earlier than the cycle after the output transfer.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL enter IDLE with sum=0, cnt=0, out_ovf=0 and out_valid=0; in_ready is 1 from the next cycle.
REQ-027 Reset SHALL take priority over any simultaneous handshake, and a reset mid-batch SHALL discard the partial sum.

Configuration
REQ-028 Macro TRIPLE_ACC_SATURATE_EN SHALL select the overflow behaviour.
REQ-029 With TRIPLE_ACC_SATURATE_EN defined, on a carry the sum SHALL clamp to 2^SUM_W-1 and stay clamped for the rest of the batch; out_ovf=1.
REQ-030 With TRIPLE_ACC_SATURATE_EN undefined, on a carry the sum SHALL wrap modulo 2^SUM_W; out_ovf=1.

Verification (N_SAMPLES=8, SUM_W=12)
REQ-031 Reset with all inputs 0 -> out_valid=0, out_sum=0, out_ovf=0, cnt=0; in_ready=1 after rst is released.
REQ-032 8 consecutive samples of 3 with out_ready=1 -> out_valid=1 for exactly 1 cycle, the cycle after the 8th handshake; out_sum=24, out_ovf=0.
REQ-033 8 samples of 765 -> without the macro out_sum=2024, out_ovf=1; with the macro out_sum=4095, out_ovf=1; a following batch of 8 samples of 1 -> out_sum=8, out_ovf=0.
REQ-034 Batch of 8 samples of 10 with out_ready=0 for 5 cycles and in_valid held at 1 -> in_ready=0 and out_sum=80 held steady throughout; after out_ready=1 the next batch starts counting from cnt=0.
REQ-035 in_valid toggled 1,0,0,1,0,1... with data equal to the cycle index -> only the handshake cycles are summed; cnt matches the number of handshakes.
REQ-036 rst pulsed after 3 samples of 100 -> sum=0 and cnt=0; a following full batch of 8 samples of 100 -> out_sum=800.
